// File: rtl/strela_pkg.sv
// Shared definitions for the STRELA execution controller.
// Holds the controller FSM state encoding and the default sizing constants.
package strela_pkg;

    localparam int DEF_INPUT_NODES_NUM  = 4;
    localparam int DEF_OUTPUT_NODES_NUM = 4;
    localparam int DEF_TIMEOUT_W        = 24;
    localparam int SIZE_W               = 16;
    localparam int PERF_W               = 32;

    // IDLE is encoded as zero so a cleared state register means "not running".
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } exec_state_e;

endpackage

// File: rtl/strela_exec_ctrl_if.sv
// Control/status bundle between the CSR block, the streamer datapath and the
// execution controller.
// Handshake: there is no backpressure anywhere. execute_i, abort_i, the done
// pulses, cfg_load_o, the start pulses and done_irq_o are single-cycle pulses
// that are acted on in the cycle they are high; sizes and timeout_cycles_i are
// levels; busy_o, done_o, timeout_o and aborted_o are levels.
interface strela_exec_ctrl_if #(
    parameter int IN_N = strela_pkg::DEF_INPUT_NODES_NUM,
    parameter int OUT_N = strela_pkg::DEF_OUTPUT_NODES_NUM,
    parameter int TW = strela_pkg::DEF_TIMEOUT_W
);
    import strela_pkg::*;

    logic                              execute_i;
    logic                              abort_i;
    logic [IN_N-1:0][SIZE_W-1:0]       in_size_i;
    logic [OUT_N-1:0][SIZE_W-1:0]      out_size_i;
    logic [TW-1:0]                     timeout_cycles_i;
    logic [IN_N-1:0]                   in_done_i;
    logic [OUT_N-1:0]                  out_done_i;
    logic                              cfg_load_o;
    logic [IN_N-1:0]                   in_start_o;
    logic [OUT_N-1:0]                  out_start_o;
    logic                              busy_o;
    logic                              done_o;
    logic                              done_irq_o;
    logic                              timeout_o;
    logic                              aborted_o;

    // Controller side.
    modport slave (
        input  execute_i, abort_i, in_size_i, out_size_i, timeout_cycles_i,
               in_done_i, out_done_i,
        output cfg_load_o, in_start_o, out_start_o, busy_o, done_o,
               done_irq_o, timeout_o, aborted_o
    );

    // CSR / datapath side.
    modport master (
        output execute_i, abort_i, in_size_i, out_size_i, timeout_cycles_i,
               in_done_i, out_done_i,
        input  cfg_load_o, in_start_o, out_start_o, busy_o, done_o,
               done_irq_o, timeout_o, aborted_o
    );

endinterface

// File: rtl/strela_done_tracker.sv
// Sticky completion tracker for one group of streamer channels.
// Latches the enable mask (nonzero size) on load_i, collects done pulses of
// enabled channels while capture_i is high, and reports when every enabled
// channel has finished, counting pulses arriving in the current cycle.
module strela_done_tracker
    import strela_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic                    capture_i,
    input  logic [N-1:0][SIZE_W-1:0] size_i,
    input  logic [N-1:0]            done_i,
    output logic [N-1:0]            mask_o,
    output logic                    all_done_o
);

    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] sticky_q, sticky_d;

    // Next mask and sticky bits; done pulses of disabled channels are masked off.
    always_comb begin
        mask_d   = mask_q;
        sticky_d = sticky_q;
        if (load_i) begin
            for (int i = 0; i < N; i++) begin
                mask_d[i] = (size_i[i] != '0);
            end
        end
        if (clear_i) begin
            sticky_d = '0;
        end else if (capture_i) begin
            sticky_d = sticky_q | (done_i & mask_q);
        end
    end

    // Mask and sticky registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q   <= '0;
            sticky_q <= '0;
        end else begin
            mask_q   <= mask_d;
            sticky_q <= sticky_d;
        end
    end

    assign mask_o     = mask_q;
    assign all_done_o = ((sticky_q | (done_i & mask_q)) == mask_q);

endmodule

// File: rtl/strela_exec_ctrl.sv
// STRELA execution controller: sequences configuration load, channel launch,
// completion wait with watchdog, and finish/abort reporting.
// Optional macro STRELA_EXEC_PERF_CNT_EN adds cycle_count_o, the number of
// cycles spent from LAUNCH through FINISH of the most recent run.
module strela_exec_ctrl
    import strela_pkg::*;
#(
    parameter int INPUT_NODES_NUM  = DEF_INPUT_NODES_NUM,
    parameter int OUTPUT_NODES_NUM = DEF_OUTPUT_NODES_NUM,
    parameter int TIMEOUT_W        = DEF_TIMEOUT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    strela_exec_ctrl_if.slave    bus,
    output exec_state_e          state_o
`ifdef STRELA_EXEC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]    cycle_count_o
`endif
);

    exec_state_e            state_q, state_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   aborted_q, aborted_d;
    logic [TIMEOUT_W-1:0]   wd_q, wd_d;
    logic                   accept;
    logic                   capture;
    logic [INPUT_NODES_NUM-1:0]  in_mask;
    logic [OUTPUT_NODES_NUM-1:0] out_mask;
    logic                   in_all_done, out_all_done;

    assign capture = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);

    strela_done_tracker #(.N(INPUT_NODES_NUM)) u_in_trk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (accept),
        .load_i     (state_q == ST_LOAD),
        .capture_i  (capture),
        .size_i     (bus.in_size_i),
        .done_i     (bus.in_done_i),
        .mask_o     (in_mask),
        .all_done_o (in_all_done)
    );

    strela_done_tracker #(.N(OUTPUT_NODES_NUM)) u_out_trk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (accept),
        .load_i     (state_q == ST_LOAD),
        .capture_i  (capture),
        .size_i     (bus.out_size_i),
        .done_i     (bus.out_done_i),
        .mask_o     (out_mask),
        .all_done_o (out_all_done)
    );

    // Next-state logic; abort in any running state overrides the normal flow.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        aborted_d = aborted_q;
        wd_d      = wd_q;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.execute_i && !bus.abort_i) begin
                    accept    = 1'b1;
                    state_d   = ST_LOAD;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            ST_LOAD: state_d = ST_LAUNCH;
            ST_LAUNCH: begin
                wd_d = '0;
                if (in_mask == '0 && out_mask == '0) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + TIMEOUT_W'(1);
                // Completion is checked first so it wins a tie with the watchdog.
                if (in_all_done && out_all_done) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end else if (bus.timeout_cycles_i != '0 && wd_d == bus.timeout_cycles_i) begin
                    state_d   = ST_FINISH;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && bus.abort_i) begin
            state_d   = ST_IDLE;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            aborted_d = 1'b1;
        end
    end

    // State and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            aborted_q <= aborted_d;
            wd_q      <= wd_d;
        end
    end

    assign state_o         = state_q;
    assign bus.cfg_load_o  = (state_q == ST_LOAD);
    assign bus.in_start_o  = (state_q == ST_LAUNCH) ? in_mask : '0;
    assign bus.out_start_o = (state_q == ST_LAUNCH) ? out_mask : '0;
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.done_irq_o  = (state_q == ST_FINISH) && !bus.abort_i;
    assign bus.done_o      = done_q;
    assign bus.timeout_o   = timeout_q;
    assign bus.aborted_o   = aborted_q;

`ifdef STRELA_EXEC_PERF_CNT_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    // Run-length counter: cleared on LOAD, saturating count while running, held in IDLE.
    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_LOAD) begin
            perf_d = '0;
        end else if (capture || state_q == ST_FINISH) begin
            if (perf_q != '1) begin
                perf_d = perf_q + 32'd1;
            end
        end
    end

    // Run-length counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign cycle_count_o = perf_q;
`endif

endmodule

// File: tb/tb_strela_exec_ctrl.sv
// Directed testbench for strela_exec_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge of the same cycle.
module tb_strela_exec_ctrl;
    import strela_pkg::*;

    logic        clk;
    logic        rst;
    exec_state_e st;
    int          errors;
    int          checks;
`ifdef STRELA_EXEC_PERF_CNT_EN
    logic [31:0] cyc_cnt;
`endif

    strela_exec_ctrl_if #(.IN_N(4), .OUT_N(4), .TW(24)) bus ();

    strela_exec_ctrl #(
        .INPUT_NODES_NUM  (4),
        .OUTPUT_NODES_NUM (4),
        .TIMEOUT_W        (24)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus.slave),
        .state_o (st)
`ifdef STRELA_EXEC_PERF_CNT_EN
        ,
        .cycle_count_o (cyc_cnt)
`endif
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and drop all single-cycle pulses.
    task automatic nc();
        @(posedge clk);
        #1;
        bus.execute_i  = 1'b0;
        bus.abort_i    = 1'b0;
        bus.in_done_i  = '0;
        bus.out_done_i = '0;
    endtask

    task automatic ns();
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.execute_i        = 1'b1;
        bus.abort_i          = 1'b0;
        bus.in_size_i        = '0;
        bus.out_size_i       = '0;
        bus.timeout_cycles_i = '0;
        bus.in_done_i        = '0;
        bus.out_done_i       = '0;

        // Reset: execute held high must not start anything.
        repeat (3) @(posedge clk);
        ns();
        chk("rst_state", 32'(st), 32'(ST_IDLE));
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_cfg", 32'(bus.cfg_load_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_irq", 32'(bus.done_irq_o), 0);
        chk("rst_tmo", 32'(bus.timeout_o), 0);
        chk("rst_abt", 32'(bus.aborted_o), 0);
        chk("rst_start", 32'({bus.in_start_o, bus.out_start_o}), 0);
        nc();
        rst = 1'b0;
        nc();

        // A: one input and one output channel, dones 8 cycles after LAUNCH.
        nc(); bus.execute_i = 1'b1; bus.in_size_i[0] = 16'd80; bus.out_size_i[0] = 16'd80;
        ns(); chk("a0_cfg", 32'(bus.cfg_load_o), 0);
        nc(); ns();
        chk("a1_cfg", 32'(bus.cfg_load_o), 1);
        chk("a1_busy", 32'(bus.busy_o), 1);
        chk("a1_start", 32'({bus.in_start_o, bus.out_start_o}), 0);
        nc(); ns();
        chk("a2_in_start", 32'(bus.in_start_o), 32'b0001);
        chk("a2_out_start", 32'(bus.out_start_o), 32'b0001);
        chk("a2_cfg", 32'(bus.cfg_load_o), 0);
        for (int c = 3; c <= 9; c++) begin
            nc(); ns();
            chk("a_wait_irq", 32'(bus.done_irq_o), 0);
        end
        chk("a9_state", 32'(st), 32'(ST_WAIT));
        nc(); bus.in_done_i = 4'b0001; bus.out_done_i = 4'b0001;
        ns(); chk("a10_irq", 32'(bus.done_irq_o), 0);
        nc(); ns();
        chk("a11_irq", 32'(bus.done_irq_o), 1);
        chk("a11_done", 32'(bus.done_o), 1);
        chk("a11_tmo", 32'(bus.timeout_o), 0);
        nc(); ns();
        chk("a12_irq", 32'(bus.done_irq_o), 0);
        chk("a12_busy", 32'(bus.busy_o), 0);
        chk("a12_done", 32'(bus.done_o), 1);
`ifdef STRELA_EXEC_PERF_CNT_EN
        chk("a12_perf", cyc_cnt, 32'd10);
`endif

        // B: all sizes zero, finish two cycles after cfg_load.
        nc(); bus.execute_i = 1'b1; bus.in_size_i = '0; bus.out_size_i = '0;
        ns();
        nc(); ns();
        chk("b1_cfg", 32'(bus.cfg_load_o), 1);
        chk("b1_done_clr", 32'(bus.done_o), 0);
        nc(); ns();
        chk("b2_start", 32'({bus.in_start_o, bus.out_start_o}), 0);
        chk("b2_irq", 32'(bus.done_irq_o), 0);
        nc(); ns();
        chk("b3_irq", 32'(bus.done_irq_o), 1);
        nc(); ns();
        chk("b4_busy", 32'(bus.busy_o), 0);
`ifdef STRELA_EXEC_PERF_CNT_EN
        chk("b4_perf", cyc_cnt, 32'd2);
`endif

        // C: watchdog of 5 with no done pulses.
        nc(); bus.execute_i = 1'b1; bus.in_size_i[1] = 16'd5; bus.timeout_cycles_i = 24'd5;
        ns();
        nc(); ns();
        nc(); ns(); chk("c2_in_start", 32'(bus.in_start_o), 32'b0010);
        for (int c = 3; c <= 7; c++) begin
            nc(); ns();
            chk("c_wait_irq", 32'(bus.done_irq_o), 0);
            chk("c_wait_tmo", 32'(bus.timeout_o), 0);
        end
        nc(); ns();
        chk("c8_irq", 32'(bus.done_irq_o), 1);
        chk("c8_tmo", 32'(bus.timeout_o), 1);
        nc(); ns();
        chk("c9_busy", 32'(bus.busy_o), 0);
        chk("c9_tmo", 32'(bus.timeout_o), 1);
        chk("c9_done", 32'(bus.done_o), 1);

        // D: last done and watchdog limit in the same cycle, completion wins.
        nc(); bus.execute_i = 1'b1;
        ns();
        nc(); ns(); chk("d1_tmo_clr", 32'(bus.timeout_o), 0);
        for (int c = 2; c <= 6; c++) begin
            nc(); ns();
        end
        nc(); bus.in_done_i = 4'b0010;
        ns();
        nc(); ns();
        chk("d8_irq", 32'(bus.done_irq_o), 1);
        chk("d8_tmo", 32'(bus.timeout_o), 0);
        nc(); ns();
        chk("d9_tmo", 32'(bus.timeout_o), 0);
        chk("d9_done", 32'(bus.done_o), 1);

        // E: abort during WAIT, then a clean restart with done in LAUNCH.
        nc(); bus.execute_i = 1'b1; bus.in_size_i[1] = '0; bus.in_size_i[0] = 16'd80;
        bus.timeout_cycles_i = '0;
        ns();
        for (int c = 1; c <= 4; c++) begin
            nc(); ns();
        end
        nc(); bus.abort_i = 1'b1;
        ns(); chk("e5_busy", 32'(bus.busy_o), 1);
        nc(); bus.in_done_i = 4'b0001;
        ns();
        chk("e6_busy", 32'(bus.busy_o), 0);
        chk("e6_abt", 32'(bus.aborted_o), 1);
        chk("e6_done", 32'(bus.done_o), 0);
        chk("e6_irq", 32'(bus.done_irq_o), 0);
        nc(); ns(); chk("e7_irq", 32'(bus.done_irq_o), 0);
        nc(); ns(); chk("e8_irq", 32'(bus.done_irq_o), 0);
        nc(); bus.execute_i = 1'b1; bus.out_size_i[1] = 16'd8;
        ns();
        nc(); ns();
        chk("r1_cfg", 32'(bus.cfg_load_o), 1);
        chk("r1_abt_clr", 32'(bus.aborted_o), 0);
        nc(); bus.in_done_i = 4'b1001; bus.out_done_i = 4'b0100;
        ns();
        chk("r2_in_start", 32'(bus.in_start_o), 32'b0001);
        chk("r2_out_start", 32'(bus.out_start_o), 32'b0010);
        nc(); bus.execute_i = 1'b1;
        ns(); chk("r3_irq", 32'(bus.done_irq_o), 0);
        nc(); ns();
        chk("r4_irq", 32'(bus.done_irq_o), 0);
        chk("r4_cfg", 32'(bus.cfg_load_o), 0);
        nc(); bus.out_done_i = 4'b0010;
        ns(); chk("r5_irq", 32'(bus.done_irq_o), 0);
        nc(); ns(); chk("r6_irq", 32'(bus.done_irq_o), 1);
        nc(); ns(); chk("r7_busy", 32'(bus.busy_o), 0);

        // F: abort and execute together in IDLE, abort wins.
        nc(); bus.execute_i = 1'b1; bus.abort_i = 1'b1;
        ns();
        nc(); ns();
        chk("f1_busy", 32'(bus.busy_o), 0);
        chk("f1_cfg", 32'(bus.cfg_load_o), 0);
        chk("f1_abt", 32'(bus.aborted_o), 0);

        // G: reset during WAIT drops the run silently.
        nc(); bus.execute_i = 1'b1; bus.out_size_i[1] = '0;
        ns();
        nc(); ns();
        nc(); ns();
        nc(); rst = 1'b1;
        ns(); chk("g3_busy", 32'(bus.busy_o), 1);
        nc(); rst = 1'b0;
        ns();
        chk("g4_busy", 32'(bus.busy_o), 0);
        chk("g4_irq", 32'(bus.done_irq_o), 0);
        chk("g4_done", 32'(bus.done_o), 0);
        chk("g4_abt", 32'(bus.aborted_o), 0);
        nc(); bus.in_done_i = 4'b0001;
        ns(); chk("g5_irq", 32'(bus.done_irq_o), 0);
        nc(); ns();
        chk("g6_irq", 32'(bus.done_irq_o), 0);
        chk("g6_busy", 32'(bus.busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
